// File: rtl/aes_key_expand.sv
// AES-128 round-key generator. It produces one round key per advance request,
// starting from the loaded cipher key, with four S-box instances on the RotWord path.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (the product of a^2 .. a^128); this maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a_i);
        s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [127:0] key,
    input  logic         adv,
    output logic [31:0]  w_0,
    output logic [31:0]  w_1,
    output logic [31:0]  w_2,
    output logic [31:0]  w_3,
    output logic [3:0]   round,
    output logic         kvalid,
    output logic         kdone
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] w0_q, w1_q, w2_q, w3_q;
    logic [31:0] w0_d, w1_d, w2_d, w3_d;
    logic [3:0]  round_q, round_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [31:0] rot_w, sub_w, t_w;
    logic [31:0] nw0, nw1, nw2, nw3;

    assign rot_w = {w3_q[23:0], w3_q[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a_i(rot_w[8*g +: 8]), .s_o(sub_w[8*g +: 8]));
    end

    assign t_w = sub_w ^ {rcon_q, 24'h000000};
    assign nw0 = w0_q ^ t_w;
    assign nw1 = w1_q ^ nw0;
    assign nw2 = w2_q ^ nw1;
    assign nw3 = w3_q ^ nw2;

    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        if (ld) begin
            w0_d    = key[127:96];
            w1_d    = key[95:64];
            w2_d    = key[63:32];
            w3_d    = key[31:0];
            round_d = 4'd0;
            rcon_d  = 8'h01;
            state_d = EXPAND;
        end else if (adv && state_q == EXPAND) begin
            w0_d    = nw0;
            w1_d    = nw1;
            w2_d    = nw2;
            w3_d    = nw3;
            round_d = round_q + 4'd1;
            rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            if (round_q == 4'd9) state_d = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    // Flags follow the registered state, so no input reaches an output combinationally.
    assign w_0    = w0_q;
    assign w_1    = w1_q;
    assign w_2    = w2_q;
    assign w_3    = w3_q;
    assign round  = round_q;
    assign kvalid = (state_q != IDLE);
    assign kdone  = (state_q == DONE);
endmodule
